// File: rtl/data_memory_param.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_param
// Brief    : Parametrised fixed-latency line memory with enable/ack handshake,
//            per-byte write enables, busy indication and out-of-range errors.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_param #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic                    enable_i,
    input  logic                    write_i,
    output logic                    ack_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_OFF   = $clog2(c_BYTES);
    localparam int c_IDXW  = $clog2(DEPTH);
    localparam int c_TOP   = c_OFF + c_IDXW;
    localparam int c_CNTW  = $clog2(LATENCY + 1);
    localparam logic [c_CNTW-1:0] c_LAT = c_CNTW'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [c_CNTW-1:0]       cnt_q;
    logic [c_IDXW-1:0]       idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [c_BYTES-1:0]      be_q;
    logic                    wr_q;
    logic                    oor_q;
    logic                    ack_q;
    logic                    err_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [c_IDXW-1:0]       w_idx;
    logic                    w_oor;
    logic                    w_fire;
    // Byte-offset bits select nothing inside a line-wide memory.
    logic                    w_unused_off;

    assign w_idx        = addr_i[c_OFF +: c_IDXW];
    assign w_unused_off = ^addr_i[c_OFF-1:0];

    // Any address bit above the line index makes the request out of range.
    generate
        if (c_TOP < ADDR_WIDTH) begin : g_range_chk
            assign w_oor = |addr_i[ADDR_WIDTH-1:c_TOP];
        end else begin : g_range_none
            assign w_oor = 1'b0;
        end
    endgenerate

    // The response edge: last wait edge, where the access actually happens.
    assign w_fire = (state_q == S_WAIT) && (cnt_q == c_LAT);

    // Handshake FSM: capture at acceptance, count latency, pulse ack/err.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        idx_q   <= w_idx;
                        wdata_q <= data_i;
                        be_q    <= be_i;
                        wr_q    <= write_i;
                        oor_q   <= w_oor;
                        cnt_q   <= c_CNTW'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == c_LAT) begin
                        state_q <= S_RESP;
                        ack_q   <= 1'b1;
                        err_q   <= oor_q;
                        if (!wr_q) begin
                            rdata_q <= oor_q ? '0 : mem_q[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q + c_CNTW'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Array write with byte enables; not reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_fire && wr_q && !oor_q) begin
            for (int k = 0; k < c_BYTES; k++) begin
                if (be_q[k]) begin
                    mem_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign ack_o  = ack_q;
    assign err_o  = err_q;
    assign busy_o = busy_q;
    assign data_o = rdata_q;

endmodule
`default_nettype wire
